// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encodings and default bus widths used by the
// bridge and by APB completer blocks.
package apb_pkg;

    localparam int APB_ADDR_W  = 32;
    localparam int APB_DATA_W  = 32;
    localparam int APB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase wait counter: cleared before ACCESS, counts stalled cycles, and flags
// expiry on the stalled cycle that reaches TIMEOUT-1. TIMEOUT=0 never expires.
module apb_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (TIMEOUT > 0) && i_enable && (r_count == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: one command in flight, SETUP then ACCESS, result parked in a
// one-deep response register until the requester takes it.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic              apb_pclk,
    input  logic              apb_prst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              apb_psel,
    output logic              apb_penable,
    output logic              apb_pwrite,
    output logic [ADDR_W-1:0] apb_paddr,
    output logic [DATA_W-1:0] apb_pwdata,
    input  logic [DATA_W-1:0] apb_prdata,
    input  logic              apb_pready,
    input  logic              apb_pslverr,
    output logic [1:0]        o_dbg_state
);

    apb_state_e        r_state;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;

    logic w_cmd_ready;
    logic w_tmo_clear;
    logic w_tmo_en;
    logic w_tmo_expire;

    // Accepting only with an empty response register keeps exactly one command in flight.
    assign w_cmd_ready = (r_state == ST_IDLE) && !r_rsp_valid;
    assign w_tmo_clear = (r_state == ST_SETUP);
    assign w_tmo_en    = (r_state == ST_ACCESS) && !apb_pready;

    apb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .i_clk    (apb_pclk),
        .i_rst    (apb_prst),
        .i_clear  (w_tmo_clear),
        .i_enable (w_tmo_en),
        .o_expire (w_tmo_expire)
    );

    always_ff @(posedge apb_pclk) begin
        if (apb_prst) begin
            r_state       <= ST_IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid   <= 1'b0;
                r_rsp_rdata   <= '0;
                r_rsp_err     <= 1'b0;
                r_rsp_timeout <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && w_cmd_ready) begin
                        r_pwrite  <= cmd_write;
                        r_paddr   <= cmd_addr;
                        r_pwdata  <= cmd_wdata;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A ready completer beats an expiring counter in the same cycle.
                    if (apb_pready) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_pwrite ? '0 : apb_prdata;
                        r_rsp_err     <= apb_pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else if (w_tmo_expire) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = w_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
    assign apb_psel    = r_psel;
    assign apb_penable = r_penable;
    assign apb_pwrite  = r_pwrite;
    assign apb_paddr   = r_paddr;
    assign apb_pwdata  = r_pwdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed and randomized transfers against an APB completer model; responses are
// predicted from wait-state count and completer data, and checked on the falling edge.
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          prst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic [1:0]    dbg_state;

    int checks   = 0;
    int failures = 0;
    // expected response: {timeout, err, rdata}
    logic [DW+1:0] exp_q[$];

    always #5 clk = ~clk;

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .apb_pclk    (clk),
        .apb_prst    (prst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .apb_psel    (psel),
        .apb_penable (penable),
        .apb_pwrite  (pwrite),
        .apb_paddr   (paddr),
        .apb_pwdata  (pwdata),
        .apb_prdata  (prdata),
        .apb_pready  (pready),
        .apb_pslverr (pslverr),
        .o_dbg_state (dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Issue one command starting at the current falling edge and play the completer:
    // pready rises on ACCESS cycle waits+1; a stall of TO cycles must end in a timeout.
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int waits, input logic [DW-1:0] rd, input logic err);
        bit to;
        int n, g, cyc, acc;
        to = (waits >= TO);
        n  = to ? TO : waits + 1;
        exp_q.push_back(to ? {1'b1, 1'b1, {DW{1'b0}}} : {1'b0, err, (wr ? {DW{1'b0}} : rd)});

        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        g = 0;
        while (!cmd_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("cmd_ready_wait", 64'(g < 50), 64'd1);

        @(negedge clk);
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = ~wr;
        chk("setup_sel_en", {psel, penable}, 2'b10);
        chk("setup_addr", paddr, addr);
        chk("setup_write", pwrite, wr);
        if (wr) chk("setup_wdata", pwdata, wdata);

        cyc = 1; acc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) break;
            acc++;
            chk("access_sel_en", {psel, penable}, 2'b11);
            chk("access_addr", paddr, addr);
            chk("access_write", pwrite, wr);
            if (wr) chk("access_wdata", pwdata, wdata);
            pready  = (acc == waits + 1);
            prdata  = pready ? rd : DW'($urandom);
            pslverr = pready ? err : 1'($urandom);
        end
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
        chk("latency", cyc, n + 2);
        chk("access_cycles", acc, n);
        chk("done_sel_en", {psel, penable}, 2'b00);
    endtask

    // Check the parked response, hold rsp_ready low for `hold` cycles, then consume it.
    task automatic take_rsp(input int hold, input bit expect_blocked);
        logic [DW+1:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        for (int i = 0; i <= hold; i++) begin
            chk("rsp_valid", rsp_valid, 1'b1);
            chk("rsp_rdata", rsp_rdata, e[DW-1:0]);
            chk("rsp_err", rsp_err, e[DW]);
            chk("rsp_timeout", rsp_timeout, e[DW+1]);
            if (expect_blocked) chk("cmd_blocked", cmd_ready, 1'b0);
            if (i < hold) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_cleared", rsp_valid, 1'b0);
    endtask

    initial begin
        prst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_apb", {psel, penable, pwrite}, 3'b000);
        chk("rst_addr", paddr, 32'h0);
        chk("rst_wdata", pwdata, 32'h0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_state", dbg_state, 2'd0);
        prst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1'b1);

        // zero-wait write
        issue(1'b1, 32'h40, 32'hA5A5_0001, 0, 32'h0, 1'b0);
        take_rsp(0, 1'b0);
        // read with three wait states
        issue(1'b0, 32'h48, 32'h0, 3, 32'h0001_E002, 1'b0);
        take_rsp(0, 1'b0);
        // read with slave error
        issue(1'b0, 32'h4C, 32'h0, 1, 32'hDEAD_0003, 1'b1);
        take_rsp(0, 1'b0);
        // stuck completer times out; ready on the last allowed cycle still completes
        issue(1'b0, 32'h50, 32'h0, 40, 32'hFFFF_FFFF, 1'b0);
        take_rsp(0, 1'b0);
        issue(1'b0, 32'h54, 32'h0, TO - 1, 32'h1234_5678, 1'b0);
        take_rsp(0, 1'b0);

        // response backpressure with a pending command
        issue(1'b1, 32'h60, 32'h0BAD_F00D, 2, 32'h0, 1'b1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h64; cmd_wdata = 32'h0;
        take_rsp(10, 1'b1);
        chk("accept_after_handshake", cmd_ready, 1'b1);
        issue(1'b0, 32'h64, 32'h0, 0, 32'h7777_0064, 1'b0);
        take_rsp(1, 1'b0);

        // reset during ACCESS drops the transfer
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h70; cmd_wdata = 32'h1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_access", {psel, penable}, 2'b11);
        prst = 1'b1;
        @(negedge clk);
        prst = 1'b0;
        chk("mid_reset_outputs", {psel, penable, rsp_valid}, 3'b000);
        chk("mid_reset_ready", cmd_ready, 1'b1);
        issue(1'b1, 32'h74, 32'hCAFE_0074, 1, 32'h0, 1'b0);
        take_rsp(0, 1'b0);

        // randomized transfers, including some that time out
        for (int t = 0; t < 20; t++) begin
            logic          w, e;
            logic [AW-1:0] a;
            logic [DW-1:0] wd, rd;
            int            ws;
            w  = 1'($urandom);
            e  = ($urandom_range(0, 3) == 0);
            a  = {$urandom_range(0, 255), 2'b00};
            wd = $urandom;
            rd = $urandom;
            ws = ($urandom_range(0, 4) == 0) ? $urandom_range(TO - 1, TO + 4) : $urandom_range(0, 5);
            issue(w, a, wd, ws, rd, e);
            take_rsp($urandom_range(0, 3), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
